// File: rtl/async_fifo_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter: FSM encoding,
// default geometry and a one-hot to index helper.
package async_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_N         = 4;
  localparam int DEF_MAX_BURST = 8;

  // Requester count never exceeds 8, so an 8-bit vector covers every case.
  function automatic int onehot_to_idx(input logic [7:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns a one-hot selection of the first
// set request found searching upward from last_owner+1 (mod N).
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_owner,
  output logic [N-1:0]         pick
);

  logic found;
  int   idx;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_owner) + k) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of an async FIFO: one requester owns the
// FIFO write port for up to MAX_BURST words, with a single idle bubble between grants.
module fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N         = DEF_N,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               wr_clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] req_din,
  output logic [N-1:0]       ack,
  output logic [N-1:0]       gnt,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [WIDTH-1:0]   fifo_din
);

  localparam int LW = $clog2(N);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);

  state_t          state;
  state_t          next_state;
  logic [LW-1:0]   owner;
  logic [LW-1:0]   last_owner;
  logic [BW-1:0]   burst_cnt;
  logic [N-1:0]    pick;
  logic            burst_end;

  rr_pick #(.N(N)) u_rr_pick (
    .req        (req),
    .last_owner (last_owner),
    .pick       (pick)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A stalled burst-end word is not written, so it cannot end the burst.
  assign burst_end = fifo_wr_en && (burst_cnt == LAST_CNT);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (|req) next_state = GRANT;
      GRANT: if (!req[owner] || burst_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    fifo_wr_en = 1'b0;
    ack        = '0;
    fifo_din   = '0;
    if (state == GRANT) begin
      fifo_wr_en = req[owner] & ~fifo_full;
      ack        = gnt & {N{req[owner] & ~fifo_full}};
      fifo_din   = req_din[int'(owner)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      owner      <= '0;
      burst_cnt  <= '0;
      last_owner <= LW'(N - 1);
    end else if (state == IDLE) begin
      if (|req) begin
        gnt       <= pick;
        owner     <= LW'(onehot_to_idx(8'(pick)));
        burst_cnt <= '0;
      end
    end else if (next_state == IDLE) begin
      gnt        <= '0;
      last_owner <= owner;
    end else if (fifo_wr_en) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N=4, WIDTH=16, MAX_BURST=8).
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_din;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_din;

  int tests = 0;
  int fails = 0;

  fifo_wr_arbiter #(.WIDTH(16), .N(4), .MAX_BURST(8)) dut (
    .wr_clk     (wr_clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_din    (req_din),
    .ack        (ack),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #2;
  endtask

  // Runs one grant from its first cycle, stalling the FIFO for full_len cycles
  // starting at grant cycle full_from; expects 8 words over exp_cycles cycles.
  task automatic burst(input logic [3:0] exp_gnt, input int full_from, input int full_len,
                       input int exp_cycles);
    int cyc;
    int writes;
    cyc    = 0;
    writes = 0;
    while (cyc < 40) begin
      fifo_full = (cyc >= full_from) && (cyc < full_from + full_len);
      #1;
      if (gnt == 4'b0000) break;
      if (fifo_full) begin
        check("full_no_ack", 32'(ack), 32'h0);
        check("full_gnt_held", 32'(gnt), 32'(exp_gnt));
      end
      if (ack == exp_gnt) writes++;
      tick();
      cyc++;
    end
    fifo_full = 1'b0;
    check("burst_words", 32'(writes), 32'd8);
    check("burst_cycles", 32'(cyc), 32'(exp_cycles));
  endtask

  initial begin
    logic [3:0]  exp_g;
    logic [15:0] exp_d;

    rst_n     = 1'b0;
    req       = 4'b1111;
    fifo_full = 1'b0;
    req_din   = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_din", 32'(fifo_din), 32'h0);

    // Release reset with all requesters active: requester 0 wins first.
    rst_n = 1'b1;
    tick();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_din", 32'(fifo_din), 32'hD000);

    // Full rotation: 8 words per owner plus one bubble = 9 cycles each.
    for (int c = 0; c < 36; c++) begin
      exp_g = ((c % 9) < 8) ? 4'(1 << (c / 9)) : 4'b0000;
      exp_d = ((c % 9) < 8) ? 16'(16'hD000 + c / 9) : 16'h0000;
      check("rot_gnt", 32'(gnt), 32'(exp_g));
      check("rot_ack", 32'(ack), 32'(exp_g));
      check("rot_din", 32'(fifo_din), 32'(exp_d));
      tick();
    end
    check("rot_wrap", 32'(gnt), 32'h1);

    // Reset during owner 1's fifth word: outputs drop at once, restart at 0.
    repeat (13) tick();
    check("pre_rst_gnt", 32'(gnt), 32'h2);
    check("pre_rst_ack", 32'(ack), 32'h2);
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("async_rst_ack", 32'(ack), 32'h0);
    check("async_rst_din", 32'(fifo_din), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    check("restart_gnt", 32'(gnt), 32'h1);

    // Fresh reset with no requests: stays idle.
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_wr_en", 32'(fifo_wr_en), 32'h0);

    // Single requester 2, three words then drop.
    req = 4'b0100;
    #1;
    check("latency_no_write", 32'(fifo_wr_en), 32'h0);
    tick();
    check("r2_gnt", 32'(gnt), 32'h4);
    check("r2_ack1", 32'(ack), 32'h4);
    check("r2_din", 32'(fifo_din), 32'hD002);
    tick();
    check("r2_ack2", 32'(ack), 32'h4);
    tick();
    check("r2_ack3", 32'(ack), 32'h4);
    req = 4'b0000;
    #1;
    check("r2_drop_wr_en", 32'(fifo_wr_en), 32'h0);
    check("r2_drop_gnt", 32'(gnt), 32'h4);
    tick();
    check("r2_released", 32'(gnt), 32'h0);

    // Round robin resumes after requester 2: requester 3 wins over 0 and 1.
    req = 4'b1011;
    tick();
    check("rr_after_2", 32'(gnt), 32'h8);
    req = 4'b1000;
    #1;
    check("non_owner_drop", 32'(gnt), 32'h8);

    // Stall 5 cycles mid-burst: 8 words over 13 grant cycles.
    burst(4'b1000, 3, 5, 13);
    check("bubble_gnt", 32'(gnt), 32'h0);
    tick();
    check("regrant_3", 32'(gnt), 32'h8);

    // Stall exactly on the burst-end word: grant held, word written later.
    burst(4'b1000, 7, 2, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
